mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-way arbiter that shares one physical-memory port between the CPU's instruction-side cache (read-only) and data-side cache (read/write). It sits between the I-cache/D-cache miss interfaces and main memory, below the pipelined datapath's `imem_*`/`dmem_*` ports. Each transaction is a full cache line, and only one is outstanding at a time. Grants alternate round-robin under contention.

## Interface
Parameters:
- `LINE_W`, default 256: cache-line width in bits.
- `ADDR_W`, default 32: address width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset. Asynchronous, active-high; the polarity and synchronicity are fixed.
- `i_read`  in  1: I-side read request. Held until `i_resp`.
- `i_address`  in  `ADDR_W`: I-side line address.
- `i_rdata`  out  `LINE_W`: I-side read data.
- `i_resp`  out  1: I-side completion, one-cycle pulse.
- `d_read`  in  1: D-side read request. Held until `d_resp`.
- `d_write`  in  1: D-side write request. Held until `d_resp`.
- `d_address`  in  `ADDR_W`: D-side line address.
- `d_wdata`  in  `LINE_W`: D-side write data.
- `d_rdata`  out  `LINE_W`: D-side read data.
- `d_resp`  out  1: D-side completion, one-cycle pulse.
- `p_read`  out  1: memory read strobe.
- `p_write`  out  1: memory write strobe.
- `p_address`  out  `ADDR_W`: memory address.
- `p_wdata`  out  `LINE_W`: memory write data.
- `p_rdata`  in  `LINE_W`: memory read data.
- `p_resp`  in  1: memory completion pulse.

## Operation
- FSM states: `ARB_IDLE`, `ARB_I`, `ARB_D`. Plus one flop `last_d`, set to 1 when the last grant went to the D side.
- Transitions out of IDLE:
  - Only I requesting: go to `ARB_I`.
  - Only D requesting (read or write): go to `ARB_D`.
  - Both requesting: go to `ARB_I` if `last_d` = 1, else `ARB_D`.
  - Neither requesting: stay in IDLE.
- Transitions out of `ARB_I` / `ARB_D`: stay until `p_resp` = 1, then go to IDLE. `last_d` updates on entry to a serve state.
- In `ARB_I`: `p_read` = `i_read`, `p_write` = 0, `p_address` = `i_address`.
- In `ARB_D`: `p_read` = `d_read & ~d_write`, `p_write` = `d_write`, `p_address` = `d_address`.
  - `d_read` and `d_write` together is illegal. Write wins.
- `p_wdata` = `d_wdata` at all times.
- `i_rdata` = `d_rdata` = `p_rdata` at all times (pass-through).
- Response steering:
  - `i_resp` = `p_resp` while in `ARB_I`, else 0.
  - `d_resp` = `p_resp` while in `ARB_D`, else 0.
- In IDLE, `p_read`/`p_write` are 0, and any `p_resp` is ignored.
- If a requester drops its request mid-serve (protocol violation), the strobe drops with it. The FSM still waits for `p_resp`.

## Timing
- Reset values:
  - State = `ARB_IDLE`, `last_d` = 0, so D wins the first tie.
  - `p_read`/`p_write`/`i_resp`/`d_resp` = 0 immediately and asynchronously.
- Latency:
  - Request seen in IDLE at edge n.
  - Memory strobe asserted during cycle n+1.
  - Requester's resp is combinational and coincides with `p_resp`.
  - FSM is back in IDLE the cycle after `p_resp`.
- One mandatory IDLE bubble separates consecutive grants. It guarantees the requester has deasserted after its resp before re-arbitration.
- All strobe outputs are decoded from registered state plus requester inputs only. There is no combinational path from `p_resp` to `p_read`/`p_write`.
- Reset mid-transaction: the transaction is abandoned and strobes drop at once. A `p_resp` arriving after reset, while in IDLE, is dropped.

## Structure
- Package `arb_types`: `arb_state_t` enum with the three state values.
- Sub-module `rr_pick2` (2-way round-robin picker).
  - Inputs: `req_i`, `req_d`, `last_d`.
  - Outputs: `gnt_i`, `gnt_d`.
  - Combinational. The FSM and flops stay in `mem_arbiter`.

## Test plan
- **Lone I read:** `i_read`=1, `i_address`=0x0000_0100; memory answers 3 cycles later with `p_rdata`=0xA5…A5. Required: `p_read`=1 and `p_address`=0x100 from cycle 1; `i_resp`=1 with `i_rdata`=0xA5…A5; `d_resp` stays 0.
- **Lone D write:** `d_write`=1, `d_address`=0x8000_0040, `d_wdata`=0x1234…. Required: `p_write`=1, `p_read`=0, `d_resp` pulses exactly once.
- **Simultaneous after reset:** I and D both request at cycle 0. Required: D served first, IDLE bubble, then I served. Order on `p_address` is D address then I address.
- **Round-robin under contention:** D issues back-to-back requests while I holds `i_read`. Required: grants alternate D, I, D; I waits at most one D transaction.
- **Reset mid-serve:** `rst`=1 two cycles into an `ARB_D` read. Required: `p_read`=0 immediately; a later `p_resp` produces no `i_resp`/`d_resp`; the next tie goes to D.
- **Illegal D read+write:** `d_read`=`d_write`=1. Required: `p_write`=1, `p_read`=0, and the bench flags a protocol assertion.

Source files
------------

// File: rtl/arb_types.sv
// ----------------------------------------------------------------------------
// arb_types : shared state encoding for the memory-port arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package arb_types;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2 : combinational two-way round-robin picker
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick2 (
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic gnt_i,
  output logic gnt_d
);

  // On a tie, the side that did not win last time gets the grant.
  assign gnt_i = req_i & (~req_d | last_d);
  assign gnt_d = req_d & (~req_i | ~last_d);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter : shares one memory port between I-cache and D-cache line misses
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import arb_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              p_read,
  output logic              p_write,
  output logic [ADDR_W-1:0] p_address,
  output logic [LINE_W-1:0] p_wdata,
  input  logic [LINE_W-1:0] p_rdata,
  input  logic              p_resp
);

  arb_state_t state, next_state;
  logic       last_d;
  logic       req_d;
  logic       gnt_i, gnt_d;

  assign req_d = d_read | d_write;

  rr_pick2 u_pick (
    .req_i  (i_read),
    .req_d  (req_d),
    .last_d (last_d),
    .gnt_i  (gnt_i),
    .gnt_d  (gnt_d)
  );

  assign p_wdata = d_wdata;
  assign i_rdata = p_rdata;
  assign d_rdata = p_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      last_d <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ARB_IDLE && (gnt_i || gnt_d))
        last_d <= gnt_d;
    end
  end

  // Strobes depend only on state and requester inputs, never on p_resp.
  always_comb begin
    next_state = state;
    p_read     = 1'b0;
    p_write    = 1'b0;
    p_address  = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (gnt_d)
          next_state = ARB_D;
        else if (gnt_i)
          next_state = ARB_I;
      end
      ARB_I: begin
        p_read    = i_read;
        p_address = i_address;
        i_resp    = p_resp;
        if (p_resp)
          next_state = ARB_IDLE;
      end
      ARB_D: begin
        // Write wins if both strobes are (illegally) raised together.
        p_read    = d_read & ~d_write;
        p_write   = d_write;
        p_address = d_address;
        d_resp    = p_resp;
        if (p_resp)
          next_state = ARB_IDLE;
      end
      default: next_state = ARB_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter : directed scoreboard bench for mem_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              p_read;
  logic              p_write;
  logic [ADDR_W-1:0] p_address;
  logic [LINE_W-1:0] p_wdata;
  logic [LINE_W-1:0] p_rdata;
  logic              p_resp;

  mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_address (i_address),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_address (d_address),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .p_read    (p_read),
    .p_write   (p_write),
    .p_address (p_address),
    .p_wdata   (p_wdata),
    .p_rdata   (p_rdata),
    .p_resp    (p_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                d;
    logic [ADDR_W-1:0] addr;
    bit                wr;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   waited;

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_txn(input bit d, input logic [ADDR_W-1:0] addr, input bit wr);
    txn_t t;
    t.d = d; t.addr = addr; t.wr = wr;
    exp_q.push_back(t);
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  // Memory model: waits for a strobe, checks it against the scoreboard head,
  // then answers after lat cycles with rdata. Returns at posedge+1 after resp.
  task automatic serve(input logic [LINE_W-1:0] rdata, input int lat, output int n);
    txn_t e;
    n = 0;
    @(negedge clk);
    while (!(p_read || p_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard: observed=strobe expected=no transaction");
      return;
    end
    e = exp_q.pop_front();
    if (n >= 20) begin
      checks++; errors++;
      $error("FAIL strobe_timeout: observed=none expected=addr %0h", e.addr);
      return;
    end
    check("p_address", p_address, e.addr);
    check("p_write", p_write, e.wr);
    check("p_read", p_read, !e.wr);
    check("p_wdata", p_wdata, d_wdata);
    check("early_resp", {i_resp, d_resp}, 2'b00);
    repeat (lat - 1) @(negedge clk);
    p_rdata = rdata;
    p_resp  = 1'b1;
    #1;
    check("i_resp", i_resp, !e.d);
    check("d_resp", d_resp, e.d);
    check("rdata", e.d ? d_rdata : i_rdata, rdata);
    @(posedge clk); #1;
    p_resp = 1'b0;
  endtask

  task automatic bubble();
    @(negedge clk);
    check("bubble_read", p_read, 1'b0);
    check("bubble_write", p_write, 1'b0);
    check("bubble_resp", {i_resp, d_resp}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    p_rdata = '0; p_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_read", p_read, 1'b0);
    check("reset_write", p_write, 1'b0);
    check("reset_resp", {i_resp, d_resp}, 2'b00);
    rst = 1'b0;

    // Simultaneous requests after reset: D first, then I.
    align();
    i_read = 1'b1; i_address = 32'h0000_0200;
    d_read = 1'b1; d_address = 32'h0000_0300;
    expect_txn(1'b1, 32'h0000_0300, 1'b0);
    expect_txn(1'b0, 32'h0000_0200, 1'b0);
    serve({8{32'hDDDD_0001}}, 2, waited);
    d_read = 1'b0;
    bubble();
    serve({8{32'h1111_0002}}, 2, waited);
    i_read = 1'b0;
    bubble();

    // Lone I read, memory answers 3 cycles after strobe.
    align();
    i_read = 1'b1; i_address = 32'h0000_0100;
    expect_txn(1'b0, 32'h0000_0100, 1'b0);
    serve({32{8'hA5}}, 3, waited);
    check("i_strobe_latency", waited, 1);
    i_read = 1'b0;
    bubble();

    // Lone D write.
    align();
    d_write = 1'b1; d_address = 32'h8000_0040;
    d_wdata = {8{32'h1234_5678}};
    expect_txn(1'b1, 32'h8000_0040, 1'b1);
    serve('0, 2, waited);
    d_write = 1'b0;
    bubble();

    // Round-robin: D back-to-back while I holds its request.
    align();
    d_read = 1'b1; d_address = 32'h0000_0400;
    expect_txn(1'b1, 32'h0000_0400, 1'b0);
    align();
    i_read = 1'b1; i_address = 32'h0000_0500;
    expect_txn(1'b0, 32'h0000_0500, 1'b0);
    expect_txn(1'b1, 32'h0000_0440, 1'b1);
    serve({8{32'h0400_0400}}, 2, waited);
    d_read = 1'b0; d_write = 1'b1; d_address = 32'h0000_0440;
    d_wdata = {8{32'hCAFE_F00D}};
    bubble();
    serve({8{32'h0500_0500}}, 1, waited);
    i_read = 1'b0;
    bubble();
    serve('0, 2, waited);
    d_write = 1'b0;
    bubble();

    // Reset during a D read.
    align();
    d_read = 1'b1; d_address = 32'h0000_0600;
    @(negedge clk); @(negedge clk);
    check("pre_reset_read", p_read, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("reset_drop_read", p_read, 1'b0);
    check("reset_drop_resp", {i_resp, d_resp}, 2'b00);
    d_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    p_resp = 1'b1; p_rdata = {8{32'hDEAD_BEEF}};
    #1;
    check("stray_resp", {i_resp, d_resp}, 2'b00);
    @(posedge clk); #1;
    p_resp = 1'b0;
    check("stray_state", p_read | p_write, 1'b0);
    align();
    i_read = 1'b1; i_address = 32'h0000_0700;
    d_read = 1'b1; d_address = 32'h0000_0800;
    expect_txn(1'b1, 32'h0000_0800, 1'b0);
    expect_txn(1'b0, 32'h0000_0700, 1'b0);
    serve({8{32'h0800_0800}}, 2, waited);
    d_read = 1'b0;
    bubble();
    serve({8{32'h0700_0700}}, 2, waited);
    i_read = 1'b0;
    bubble();

    // Illegal D read+write together: write must win.
    align();
    $display("protocol warning: driving d_read and d_write together");
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0900;
    d_wdata = {8{32'h0BAD_0BAD}};
    expect_txn(1'b1, 32'h0000_0900, 1'b1);
    serve('0, 2, waited);
    d_read = 1'b0; d_write = 1'b0;
    bubble();

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
